// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: lock FSM states,
// port identifiers and the registered request carried through stage 1.
package dmem_arb_pkg;

  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_FUNC3_W = 3;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic {
    ARB_RR     = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                    we;
    logic [DMEM_FUNC3_W-1:0] func3;
    logic [DMEM_DATA_W-1:0]  addr;
    logic [DMEM_DATA_W-1:0]  wdata;
    logic                    owner;
  } mem_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant: the port not served last wins a tie, and
// while locked only the debug port (port 1) can be granted.
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  input  logic locked,
  output logic grant0,
  output logic grant1
);

  assign grant0 = !locked && valid0 && (!valid1 || last_grant == PORT_DBG);
  assign grant1 = valid1 && (locked || !valid0 || last_grant == PORT_CORE);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_memory between the core (port 0) and the debug loader (port 1)
// through a request stage that drives memory and a registered response stage.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DMEM_DATA_W,
  parameter int FUNC3_WIDTH = DMEM_FUNC3_W
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_we,
  input  logic [FUNC3_WIDTH-1:0] req0_func3,
  input  logic [DATA_WIDTH-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0]  req0_wdata,
  output logic                   req0_rvalid,
  output logic [DATA_WIDTH-1:0]  req0_rdata,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_we,
  input  logic [FUNC3_WIDTH-1:0] req1_func3,
  input  logic [DATA_WIDTH-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0]  req1_wdata,
  output logic                   req1_rvalid,
  output logic [DATA_WIDTH-1:0]  req1_rdata,

  input  logic                   dbg_lock,
  output logic                   lock_active,

  output logic                   mem_write_en,
  output logic [FUNC3_WIDTH-1:0] mem_func3,
  output logic [DATA_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_write_data,
  input  logic [DATA_WIDTH-1:0]  mem_read_data
);

  arb_state_t state, state_next;
  logic       last_grant;
  logic       grant0, grant1;
  mem_req_t   accept_req;
  mem_req_t   s1_req;
  logic       s1_valid;
  logic       s1_read;

  arb_rr2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .locked     (state == ARB_LOCKED),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign lock_active = (state == ARB_LOCKED);

  // NOTE: every signal written here gets a default first so no path leaves
  // a value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    accept_req = '0;

    case (state)
      ARB_RR:     if (dbg_lock)  state_next = ARB_LOCKED;
      ARB_LOCKED: if (!dbg_lock) state_next = ARB_RR;
      default:                   state_next = ARB_RR;
    endcase

    if (grant1) begin
      accept_req.we    = req1_we;
      accept_req.func3 = req1_func3;
      accept_req.addr  = req1_addr;
      accept_req.wdata = req1_wdata;
      accept_req.owner = PORT_DBG;
    end else begin
      accept_req.we    = req0_we;
      accept_req.func3 = req0_func3;
      accept_req.addr  = req0_addr;
      accept_req.wdata = req0_wdata;
      accept_req.owner = PORT_CORE;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_RR;
      last_grant <= PORT_DBG;
    end else begin
      state <= state_next;
      if (grant0)      last_grant <= PORT_CORE;
      else if (grant1) last_grant <= PORT_DBG;
    end
  end

  // NOTE: the request register is datapath, but it is reset anyway because it
  // drives the memory address/data pins, which must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else begin
      s1_valid <= grant0 || grant1;
      if (grant0 || grant1) s1_req <= accept_req;
    end
  end

  // Write strobe lives only while the accepted write sits in stage 1.
  assign mem_write_en   = s1_valid && s1_req.we;
  assign mem_func3      = s1_req.func3;
  assign mem_addr       = s1_req.addr;
  assign mem_write_data = s1_req.wdata;
  assign s1_read        = s1_valid && !s1_req.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= '0;
      req1_rdata  <= '0;
    end else begin
      req0_rvalid <= s1_read && (s1_req.owner == PORT_CORE);
      req1_rvalid <= s1_read && (s1_req.owner == PORT_DBG);
      if (s1_read && s1_req.owner == PORT_CORE) req0_rdata <= mem_read_data;
      if (s1_read && s1_req.owner == PORT_DBG)  req1_rdata <= mem_read_data;
    end
  end

endmodule
